// File: rtl/gcd_operand_bank_if.sv
// Handshake and command bundle between the GCD operand bank, its operand source,
// the controller and the result consumer.
interface gcd_operand_bank_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    cmd;
  logic [W-1:0]  a_out;
  logic [W-1:0]  b_out;
  logic          a_lt_b;
  logic          a_eq_b;
  logic          b_zero;
  logic          underflow;
  logic [CW-1:0] iter_cnt;
  logic          result_valid;
  logic          result_ready;
  logic [W-1:0]  result;

  // Environment side: operand source, controller and result consumer.
  modport master (
    output in_valid, in_a, in_b, cmd, result_ready,
    input  in_ready, a_out, b_out, a_lt_b, a_eq_b, b_zero, underflow, iter_cnt,
           result_valid, result
  );

  // Bank side.
  modport slave (
    input  in_valid, in_a, in_b, cmd, result_ready,
    output in_ready, a_out, b_out, a_lt_b, a_eq_b, b_zero, underflow, iter_cnt,
           result_valid, result
  );
endinterface

// File: rtl/gcd_operand_bank.sv
// Operand register bank for the Euclidean GCD datapath: holds A/B, executes per-cycle
// controller commands, produces comparison flags and hands out the result.
module gcd_operand_bank #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  gcd_operand_bank_if.slave   bus
);

  localparam logic [2:0] CmdNop  = 3'd0;
  localparam logic [2:0] CmdSubA = 3'd1;
  localparam logic [2:0] CmdSubB = 3'd2;
  localparam logic [2:0] CmdSwap = 3'd3;
  localparam logic [2:0] CmdClr  = 3'd4;
  localparam logic [2:0] CmdEmit = 3'd5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StOut    = 2'd2
  } state_e;

  state_e        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  logic          r_underflow;
  logic [CW-1:0] r_iter_cnt;

  state_e        w_state_nxt;
  logic [W-1:0]  w_a_nxt;
  logic [W-1:0]  w_b_nxt;
  logic [W-1:0]  w_result_nxt;
  logic          w_underflow_nxt;
  logic [CW-1:0] w_iter_cnt_nxt;
  logic          w_count;
  logic          w_a_lt_b;
  logic          w_b_lt_a;
  logic [W-1:0]  w_a_minus_b;
  logic [W-1:0]  w_b_minus_a;
  logic          w_cnt_sat;

  assign w_a_lt_b    = r_a < r_b;
  assign w_b_lt_a    = r_b < r_a;
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;
  assign w_cnt_sat   = &r_iter_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_underflow <= 1'b0;
      r_iter_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_result    <= w_result_nxt;
      r_underflow <= w_underflow_nxt;
      r_iter_cnt  <= w_iter_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_result_nxt    = r_result;
    w_underflow_nxt = r_underflow;
    w_iter_cnt_nxt  = r_iter_cnt;
    w_count         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_a_nxt         = bus.in_a;
          w_b_nxt         = bus.in_b;
          w_underflow_nxt = 1'b0;
          w_iter_cnt_nxt  = '0;
          w_state_nxt     = StActive;
        end
      end

      StActive: begin
        case (bus.cmd)
          CmdSubA: begin
            w_a_nxt = w_a_minus_b;
            w_count = 1'b1;
            if (w_a_lt_b) w_underflow_nxt = 1'b1;
          end
          CmdSubB: begin
            w_b_nxt = w_b_minus_a;
            w_count = 1'b1;
            if (w_b_lt_a) w_underflow_nxt = 1'b1;
          end
          CmdSwap: begin
            w_a_nxt = r_b;
            w_b_nxt = r_a;
            w_count = 1'b1;
          end
          CmdEmit: begin
            w_result_nxt = r_a;
            w_count      = 1'b1;
            w_state_nxt  = StOut;
          end
          default: ;
        endcase

        if (w_count && !w_cnt_sat) w_iter_cnt_nxt = r_iter_cnt + 1'b1;

        // Abort wipes the counter too, so it must win over the increment above.
        if (bus.cmd == CmdClr) begin
          w_a_nxt         = '0;
          w_b_nxt         = '0;
          w_underflow_nxt = 1'b0;
          w_iter_cnt_nxt  = '0;
          w_state_nxt     = StIdle;
        end
      end

      StOut: begin
        if (bus.result_ready) w_state_nxt = StIdle;
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  // Handshake outputs decode the state register only.
  assign bus.in_ready     = (r_state == StIdle);
  assign bus.result_valid = (r_state == StOut);
  assign bus.result       = r_result;
  assign bus.a_out        = r_a;
  assign bus.b_out        = r_b;
  assign bus.a_lt_b       = w_a_lt_b;
  assign bus.a_eq_b       = (r_a == r_b);
  assign bus.b_zero       = (r_b == '0);
  assign bus.underflow    = r_underflow;
  assign bus.iter_cnt     = r_iter_cnt;

  logic w_unused_cmd;
  assign w_unused_cmd = (CmdNop == 3'd0);

endmodule

// File: tb/tb_gcd_operand_bank.sv
// Directed bench for gcd_operand_bank: a 16-bit/8-bit-counter instance for the main
// datapath and a 4-bit/2-bit-counter instance for width and saturation corners.
module tb_gcd_operand_bank;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] SUBA = 3'd1;
  localparam logic [2:0] SUBB = 3'd2;
  localparam logic [2:0] SWAP = 3'd3;
  localparam logic [2:0] CLR  = 3'd4;
  localparam logic [2:0] EMIT = 3'd5;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  gcd_operand_bank_if #(.W(16), .CW(8)) bus0 ();
  gcd_operand_bank_if #(.W(4),  .CW(2)) bus1 ();

  gcd_operand_bank #(.W(16), .CW(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gcd_operand_bank #(.W(4),  .CW(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [15:0] a, input logic [15:0] b);
    bus0.in_valid = 1'b1;
    bus0.in_a     = a;
    bus0.in_b     = b;
    bus0.cmd      = NOP;
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic cmd0(input logic [2:0] c);
    bus0.cmd = c;
    tick();
    bus0.cmd = NOP;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (bus0.a_out !== 16'd0 || bus0.b_out !== 16'd0 || bus0.result !== 16'd0 ||
        bus0.iter_cnt !== 8'd0 || bus0.underflow !== 1'b0 || bus0.result_valid !== 1'b0 ||
        bus0.in_ready !== 1'b1 || bus0.a_eq_b !== 1'b1 || bus0.b_zero !== 1'b1 ||
        bus0.a_lt_b !== 1'b0) begin
      fails++;
      $display("FAIL %s: a=%0d b=%0d res=%0d cnt=%0d uf=%b rv=%b ir=%b eq=%b bz=%b lt=%b, want all zero except ir=eq=bz=1",
               tag, bus0.a_out, bus0.b_out, bus0.result, bus0.iter_cnt, bus0.underflow,
               bus0.result_valid, bus0.in_ready, bus0.a_eq_b, bus0.b_zero, bus0.a_lt_b);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset_initial");
    tests++;
    if (bus1.in_ready !== 1'b1 || bus1.a_out !== 4'd0 || bus1.iter_cnt !== 2'd0) begin
      fails++;
      $display("FAIL reset_initial_w4: ir=%b a=%0d cnt=%0d, want 1 0 0",
               bus1.in_ready, bus1.a_out, bus1.iter_cnt);
    end
    // Mid-cycle reset from ACTIVE.
    load0(16'd7, 16'd3);
    cmd0(SUBA);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_from_active");
    #1 rst = 1'b0;
    tick();
    // Mid-cycle reset from OUT drops the pending result.
    load0(16'd9, 16'd4);
    cmd0(EMIT);
    tests++;
    if (bus0.result_valid !== 1'b1 || bus0.result !== 16'd9) begin
      fails++;
      $display("FAIL reset_pre_out: rv=%b res=%0d, want 1 9", bus0.result_valid, bus0.result);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_from_out");
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_gcd_48_18();
    logic [2:0]  seq [9];
    logic [15:0] ea  [9];
    logic [15:0] eb  [9];
    seq = '{SUBA, SUBA, SWAP, SUBA, SWAP, SUBA, SUBA, SWAP, EMIT};
    ea  = '{16'd30, 16'd12, 16'd18, 16'd6, 16'd12, 16'd6, 16'd0, 16'd6, 16'd6};
    eb  = '{16'd18, 16'd18, 16'd12, 16'd12, 16'd6, 16'd6, 16'd6, 16'd0, 16'd0};
    load0(16'd48, 16'd18);
    tests++;
    if (bus0.a_out !== 16'd48 || bus0.b_out !== 16'd18 || bus0.in_ready !== 1'b0 ||
        bus0.a_lt_b !== 1'b0) begin
      fails++;
      $display("FAIL gcd_load: a=%0d b=%0d ir=%b lt=%b, want 48 18 0 0",
               bus0.a_out, bus0.b_out, bus0.in_ready, bus0.a_lt_b);
    end
    for (int i = 0; i < 9; i++) begin
      cmd0(seq[i]);
      tests++;
      if (bus0.a_out !== ea[i] || bus0.b_out !== eb[i] || bus0.iter_cnt !== 8'(i + 1)) begin
        fails++;
        $display("FAIL gcd_step%0d: a=%0d b=%0d cnt=%0d, want %0d %0d %0d",
                 i, bus0.a_out, bus0.b_out, bus0.iter_cnt, ea[i], eb[i], i + 1);
      end
    end
    tests++;
    if (bus0.result !== 16'd6 || bus0.result_valid !== 1'b1 || bus0.underflow !== 1'b0 ||
        bus0.b_zero !== 1'b1 || bus0.a_eq_b !== 1'b0 || bus0.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL gcd_result: res=%0d rv=%b uf=%b bz=%b eq=%b ir=%b, want 6 1 0 1 0 0",
               bus0.result, bus0.result_valid, bus0.underflow, bus0.b_zero, bus0.a_eq_b,
               bus0.in_ready);
    end
    bus0.result_ready = 1'b1;
    tick();
    bus0.result_ready = 1'b0;
    tests++;
    if (bus0.result_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.iter_cnt !== 8'd9) begin
      fails++;
      $display("FAIL gcd_accept: rv=%b ir=%b cnt=%0d, want 0 1 9",
               bus0.result_valid, bus0.in_ready, bus0.iter_cnt);
    end
  endtask

  task automatic test_underflow();
    load0(16'd3, 16'd5);
    cmd0(SUBA);
    tests++;
    if (bus0.a_out !== 16'hFFFE || bus0.underflow !== 1'b1 || bus0.b_out !== 16'd5) begin
      fails++;
      $display("FAIL uf_sub: a=%0h uf=%b b=%0d, want fffe 1 5",
               bus0.a_out, bus0.underflow, bus0.b_out);
    end
    cmd0(EMIT);
    tests++;
    if (bus0.result !== 16'hFFFE || bus0.underflow !== 1'b1 || bus0.iter_cnt !== 8'd2) begin
      fails++;
      $display("FAIL uf_emit: res=%0h uf=%b cnt=%0d, want fffe 1 2",
               bus0.result, bus0.underflow, bus0.iter_cnt);
    end
    bus0.result_ready = 1'b1;
    tick();
    bus0.result_ready = 1'b0;
    tests++;
    if (bus0.underflow !== 1'b1) begin
      fails++;
      $display("FAIL uf_hold_idle: uf=%b, want 1", bus0.underflow);
    end
    load0(16'd1, 16'd1);
    tests++;
    if (bus0.underflow !== 1'b0 || bus0.iter_cnt !== 8'd0 || bus0.a_eq_b !== 1'b1) begin
      fails++;
      $display("FAIL uf_clear: uf=%b cnt=%0d eq=%b, want 0 0 1",
               bus0.underflow, bus0.iter_cnt, bus0.a_eq_b);
    end
    // SUB_B wrap also sets the sticky flag: B=1-1 no wrap, then B=0-1 wraps.
    cmd0(SUBB);
    cmd0(SUBB);
    tests++;
    if (bus0.b_out !== 16'hFFFF || bus0.underflow !== 1'b1 || bus0.a_lt_b !== 1'b1) begin
      fails++;
      $display("FAIL uf_subb: b=%0h uf=%b lt=%b, want ffff 1 1",
               bus0.b_out, bus0.underflow, bus0.a_lt_b);
    end
    cmd0(CLR);
  endtask

  task automatic test_backpressure();
    load0(16'd21, 16'd14);
    cmd0(SUBA);
    cmd0(SWAP);
    cmd0(SUBA);
    cmd0(SUBB);
    cmd0(EMIT);
    tests++;
    if (bus0.result !== 16'd7 || bus0.result_valid !== 1'b1 || bus0.iter_cnt !== 8'd5 ||
        bus0.b_out !== 16'd0) begin
      fails++;
      $display("FAIL bp_emit: res=%0d rv=%b cnt=%0d b=%0d, want 7 1 5 0",
               bus0.result, bus0.result_valid, bus0.iter_cnt, bus0.b_out);
    end
    // Commands and a fresh operand offer must both be ignored while stalled.
    bus0.cmd      = SUBA;
    bus0.in_valid = 1'b1;
    bus0.in_a     = 16'd9;
    bus0.in_b     = 16'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (bus0.result_valid !== 1'b1 || bus0.result !== 16'd7 || bus0.in_ready !== 1'b0 ||
          bus0.a_out !== 16'd7 || bus0.iter_cnt !== 8'd5) begin
        fails++;
        $display("FAIL bp_hold%0d: rv=%b res=%0d ir=%b a=%0d cnt=%0d, want 1 7 0 7 5",
                 i, bus0.result_valid, bus0.result, bus0.in_ready, bus0.a_out, bus0.iter_cnt);
      end
    end
    bus0.cmd          = NOP;
    bus0.result_ready = 1'b1;
    tick();
    bus0.result_ready = 1'b0;
    tests++;
    if (bus0.result_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.a_out !== 16'd7) begin
      fails++;
      $display("FAIL bp_release: rv=%b ir=%b a=%0d, want 0 1 7",
               bus0.result_valid, bus0.in_ready, bus0.a_out);
    end
    tick();
    bus0.in_valid = 1'b0;
    tests++;
    if (bus0.a_out !== 16'd9 || bus0.b_out !== 16'd3 || bus0.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_reload: a=%0d b=%0d ir=%b, want 9 3 0",
               bus0.a_out, bus0.b_out, bus0.in_ready);
    end
    cmd0(CLR);
  endtask

  task automatic test_saturation_abort();
    logic [1:0] ecnt [5];
    ecnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus1.in_valid = 1'b1;
    bus1.in_a     = 4'd3;
    bus1.in_b     = 4'd5;
    tick();
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus1.cmd = SWAP;
      tick();
      tests++;
      if (bus1.iter_cnt !== ecnt[i]) begin
        fails++;
        $display("FAIL sat_swap%0d: cnt=%0d, want %0d", i, bus1.iter_cnt, ecnt[i]);
      end
    end
    bus1.cmd = 3'd6;
    tick();
    tests++;
    if (bus1.a_out !== 4'd5 || bus1.b_out !== 4'd3 || bus1.iter_cnt !== 2'd3 ||
        bus1.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL sat_reserved: a=%0d b=%0d cnt=%0d ir=%b, want 5 3 3 0",
               bus1.a_out, bus1.b_out, bus1.iter_cnt, bus1.in_ready);
    end
    bus1.cmd = CLR;
    tick();
    bus1.cmd = NOP;
    tests++;
    if (bus1.a_out !== 4'd0 || bus1.b_out !== 4'd0 || bus1.iter_cnt !== 2'd0 ||
        bus1.in_ready !== 1'b1 || bus1.result_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_clr: a=%0d b=%0d cnt=%0d ir=%b rv=%b, want 0 0 0 1 0",
               bus1.a_out, bus1.b_out, bus1.iter_cnt, bus1.in_ready, bus1.result_valid);
    end
  endtask

  task automatic test_width();
    bus1.in_valid = 1'b1;
    bus1.in_a     = 4'd15;
    bus1.in_b     = 4'd15;
    tick();
    bus1.in_valid = 1'b0;
    tests++;
    if (bus1.a_eq_b !== 1'b1 || bus1.a_lt_b !== 1'b0 || bus1.b_zero !== 1'b0) begin
      fails++;
      $display("FAIL w4_load: eq=%b lt=%b bz=%b, want 1 0 0",
               bus1.a_eq_b, bus1.a_lt_b, bus1.b_zero);
    end
    bus1.cmd = SUBA;
    tick();
    bus1.cmd = NOP;
    tests++;
    if (bus1.a_out !== 4'd0 || bus1.a_eq_b !== 1'b0 || bus1.b_zero !== 1'b0 ||
        bus1.a_lt_b !== 1'b1 || bus1.underflow !== 1'b0) begin
      fails++;
      $display("FAIL w4_sub: a=%0d eq=%b bz=%b lt=%b uf=%b, want 0 0 0 1 0",
               bus1.a_out, bus1.a_eq_b, bus1.b_zero, bus1.a_lt_b, bus1.underflow);
    end
    bus1.cmd = CLR;
    tick();
    bus1.cmd = NOP;
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    rst               = 1'b1;
    bus0.in_valid     = 1'b0;
    bus0.in_a         = '0;
    bus0.in_b         = '0;
    bus0.cmd          = NOP;
    bus0.result_ready = 1'b0;
    bus1.in_valid     = 1'b0;
    bus1.in_a         = '0;
    bus1.in_b         = '0;
    bus1.cmd          = NOP;
    bus1.result_ready = 1'b0;
    #12 rst = 1'b0;
    #2;
    test_reset();
    test_gcd_48_18();
    test_underflow();
    test_backpressure();
    test_saturation_abort();
    test_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_operand_bank.md
# gcd_operand_bank

Parametrised operand register bank for the Euclidean GCD datapath. It replaces the fixed-width single load registers with one block that:
- holds both operands A and B;
- executes per-cycle controller commands (subtract, swap, clear);
- produces comparison flags for the controller FSM;
- accepts operands and returns the result over valid/ready handshakes.

It sits between the input interface, the GCD controller and the result consumer.

## Interface
Parameters:
- W, 16, operand/result width in bits (W >= 2)
- CW, 8, width of the iteration counter (saturating)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  bank accepts operands (high only in IDLE)
- in_a  in  W  operand A
- in_b  in  W  operand B
- cmd  in  3  controller command: 0 NOP, 1 SUB_A, 2 SUB_B, 3 SWAP, 4 CLR, 5 EMIT, 6/7 reserved (treated as NOP)
- a_out  out  W  current A register
- b_out  out  W  current B register
- a_lt_b  out  1  A < B (unsigned)
- a_eq_b  out  1  A == B
- b_zero  out  1  B == 0
- underflow  out  1  sticky: a subtraction wrapped since last load
- iter_cnt  out  CW  count of executed non-NOP commands since last load, saturates at 2^CW-1
- result_valid  out  1  result offered
- result_ready  in  1  consumer accepts result
- result  out  W  GCD result (value of A captured at EMIT)

## Operation
State machine, 3 states:
- IDLE: in_ready=1; cmd ignored.
  - On in_valid&in_ready: A<=in_a, B<=in_b, iter_cnt<=0, underflow<=0, go to ACTIVE.
- ACTIVE: in_ready=0; cmd executed every cycle:
  - SUB_A: A<=A-B mod 2^W; if A<B set underflow.
  - SUB_B: B<=B-A mod 2^W; if B<A set underflow.
  - SWAP: A<=B, B<=A, simultaneously.
  - CLR: A<=0, B<=0, underflow<=0, iter_cnt<=0, go to IDLE (abort).
  - EMIT: result<=A, go to OUT.
  - Every command other than NOP/reserved increments iter_cnt (saturating), including EMIT but not CLR.
- OUT: result_valid=1; result, A, B, flags held stable; cmd ignored; in_ready=0.
  - On result_valid&result_ready: go to IDLE.
  - A/B/underflow/iter_cnt keep their values until the next load.

Flags and data outputs:
- a_lt_b, a_eq_b, b_zero are combinational from the A/B registers, so they reflect the register values in the same cycle.
- result_valid and in_ready are decoded from the state register only; no combinational path from inputs.

Reset values: state IDLE, A=0, B=0, result=0, iter_cnt=0, underflow=0. Consequently result_valid=0, in_ready=1, a_eq_b=1, b_zero=1, a_lt_b=0.

Reset asserted in any state aborts the operation immediately. A result pending in OUT is dropped.

## Timing
- Load: handshake at edge N; A/B/flags valid after edge N; first command executed at edge N+1.
- Command latency: 1 cycle (effect visible after the edge that samples cmd).
- EMIT at edge M gives result_valid=1 from edge M until the edge where result_ready is sampled high. That edge returns the bank to IDLE, and in_ready=1 in the following cycle.
- Minimum turnaround is 1 cycle in IDLE; no load in the same cycle as result accept.
- in_valid may be held high across OUT; the pair is accepted only in IDLE.
- Backpressure: result_ready low holds OUT indefinitely with all outputs stable.

## Test plan
- Reset: assert rst mid-cycle from any state → outputs immediately at reset values listed above, in_ready=1.
- GCD 48,18: load; cmd sequence SUB_A, SUB_A, SWAP, SUB_A, SWAP, SUB_A, SUB_A, EMIT → A/B trace 30/18, 12/18, 18/12, 6/12, 12/6, 6/6, 0/6. EMIT captures A=0, which is not the GCD: the controller must EMIT on b_zero after a SWAP. Insert SWAP before EMIT → result=6, iter_cnt=9, underflow=0.
- Underflow: load 3,5; SUB_A → A=2^W-2, underflow=1; held through EMIT; cleared by the next load.
- Backpressure: EMIT with result_ready=0 for 5 cycles → result_valid stays 1, result stable, in_ready=0; release → IDLE one cycle later.
- Abort and saturation: CW=2, issue 5 SWAPs → iter_cnt=3. CLR → IDLE, A=B=0. Reserved cmd 6 in ACTIVE → no change, no count.
- Width: W=4, load 15,15, SUB_A → A=0, a_eq_b=0, b_zero=0, a_lt_b=1.
